// File: rtl/shifter_arbiter_if.sv
// Bundle of request, shifter and response signals for shifter_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the requesters, the shifter and the consumer.
interface shifter_arbiter_if #(
  parameter int NBits   = 32,
  parameter int SHAMT_W = 5
);
  logic               req0_valid;
  logic               req0_ready;
  logic [NBits-1:0]   req0_data;
  logic [SHAMT_W-1:0] req0_shamt;
  logic               req1_valid;
  logic               req1_ready;
  logic [NBits-1:0]   req1_data;
  logic [SHAMT_W-1:0] req1_shamt;
  logic [NBits-1:0]   shf_data;
  logic [SHAMT_W-1:0] shf_shamt;
  logic [NBits-1:0]   shf_result;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [NBits-1:0]   rsp_data;

  modport slave (
    input  req0_valid, req0_data, req0_shamt,
    input  req1_valid, req1_data, req1_shamt,
    input  shf_result, rsp_ready,
    output req0_ready, req1_ready, shf_data, shf_shamt,
    output rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req0_valid, req0_data, req0_shamt,
    output req1_valid, req1_data, req1_shamt,
    output shf_result, rsp_ready,
    input  req0_ready, req1_ready, shf_data, shf_shamt,
    input  rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter that time-shares one combinational left shifter
// between two requesters. It handles one operation at a time:
// IDLE -> SHIFT -> RESP.
// Optional macro SHIFTER_ARB_BYPASS_EN: a request with shamt==0 skips SHIFT.
// Its operand goes straight into the response register.
module shifter_arbiter #(
  parameter int NBits   = 32,
  parameter int SHAMT_W = 5
) (
  input logic            clk,
  input logic            reset,
  shifter_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  state_t             state;
  logic               last_grant;
  logic               id;
  logic               any;
  logic               grant;
  logic [NBits-1:0]   sel_data;
  logic [SHAMT_W-1:0] sel_shamt;

  // Pick the winner. If both requesters are valid, the one not served last wins.
  always_comb begin
    any       = bus.req0_valid | bus.req1_valid;
    grant     = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    sel_data  = grant ? bus.req1_data  : bus.req0_data;
    sel_shamt = grant ? bus.req1_shamt : bus.req0_shamt;
  end

  // Readies are combinational and only assert in IDLE for the winner.
  assign bus.req0_ready = !reset && (state == IDLE) && any && !grant;
  assign bus.req1_ready = !reset && (state == IDLE) && any &&  grant;

  // Sequencer. All shifter inputs and response outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      id            <= 1'b0;
      bus.shf_data  <= '0;
      bus.shf_shamt <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            id         <= grant;
            last_grant <= grant;
`ifdef SHIFTER_ARB_BYPASS_EN
            if (sel_shamt == '0) begin
              bus.rsp_data  <= sel_data;
              bus.rsp_id    <= grant;
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end else begin
              bus.shf_data  <= sel_data;
              bus.shf_shamt <= sel_shamt;
              state         <= SHIFT;
            end
`else
            bus.shf_data  <= sel_data;
            bus.shf_shamt <= sel_shamt;
            state         <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          bus.rsp_data  <= bus.shf_result;
          bus.rsp_id    <= id;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
